// File: rtl/apb4_mem_slave.sv
// APB4 scratch/config RAM target with programmable wait states, byte-lane strobes,
// a write-protected low region and a registered error response.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for a setup phase; request fields are latched on setup
// WAIT  | access phase held with pready low until the wait budget runs out
// READY | pready high for one cycle; an accepted write commits at its closing edge
module apb4_mem_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0,
    parameter int RO_WORDS    = 0
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TOP   = LSB + IDX_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << LSB) - 64'd1);
    localparam logic [3:0]        CNT_INIT   = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                pready_nxt, pslverr_nxt;
    logic [DATA_W-1:0]   prdata_nxt;
    logic                capture;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]    index;
    logic                misaligned, out_of_range, ro_hit, err_now;

    logic [IDX_W-1:0]    lat_idx;
    logic                lat_write, lat_err;
    logic [DATA_W-1:0]   lat_wdata;
    logic [NB-1:0]       lat_strb;

    assign index        = IDX_W'(paddr >> LSB);
    assign misaligned   = (paddr & ALIGN_MASK) != '0;
    assign out_of_range = (paddr >> TOP) != '0;

    generate
        if (RO_WORDS > 0) begin : g_ro
            assign ro_hit = 32'(index) < 32'(RO_WORDS);
        end else begin : g_no_ro
            assign ro_hit = 1'b0;
        end
    endgenerate

    assign err_now = misaligned | out_of_range | (pwrite & ro_hit);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pready  <= pready_nxt;
            pslverr <= pslverr_nxt;
            prdata  <= prdata_nxt;
            if (capture) begin
                lat_idx   <= index;
                lat_write <= pwrite;
                lat_err   <= err_now;
                lat_wdata <= pwdata;
                lat_strb  <= pstrb;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pready_nxt  = 1'b0;
        pslverr_nxt = 1'b0;
        prdata_nxt  = prdata;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt   = READY;
                        pready_nxt  = 1'b1;
                        pslverr_nxt = err_now;
                        prdata_nxt  = (!pwrite && !err_now) ? mem[index] : '0;
                    end else begin
                        cnt_nxt   = CNT_INIT;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                // Dropping psel mid-access is a protocol violation: abandon quietly.
                if (!psel) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (penable) begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt   = READY;
                        pready_nxt  = 1'b1;
                        pslverr_nxt = lat_err;
                        prdata_nxt  = (!lat_write && !lat_err) ? mem[lat_idx] : '0;
                    end
                end
            end
            READY: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Async reset forces IDLE, so an aborted transfer can never reach this commit.
    always_ff @(posedge pclk) begin
        if (state == READY && lat_write && !lat_err) begin
            for (int i = 0; i < NB; i++) begin
                if (lat_strb[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Randomized scoreboard bench for apb4_mem_slave: three instances with different
// wait-state / read-only settings share one APB bus, each with its own psel.
`timescale 1ns/1ps

module tb_apb4_mem_slave;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic [31:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    int          sel;

    logic        psel_v    [3];
    logic [31:0] prdata_v  [3];
    logic        pready_v  [3];
    logic        pslverr_v [3];

    always #5 pclk = ~pclk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            assign psel_v[g] = psel && (sel == g);
            apb4_mem_slave #(
                .DATA_W(32), .ADDR_W(32), .DEPTH(256),
                .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 5)),
                .RO_WORDS(g == 0 ? 4 : 0)
            ) u_dut (
                .pclk(pclk), .preset_n(preset_n), .paddr(paddr),
                .psel(psel_v[g]), .penable(penable), .pwrite(pwrite),
                .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_v[g]),
                .pready(pready_v[g]), .pslverr(pslverr_v[g])
            );
        end
    endgenerate

    function automatic int waits_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
    endfunction

    function automatic int ro_of(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    typedef struct {
        int          k;
        logic [31:0] data;
        logic [31:0] mask;
        logic        err;
        int          waits;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          wcnt  = 0;

    // Reference memory per instance; a byte is only compared once the bench knows it.
    logic [31:0] mdat   [3][256];
    logic [3:0]  mknown [3][256];

    task automatic issue(input int k, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd, input logic [3:0] st);
        exp_t e;
        int   w;
        logic mis, oor, ro;
        bit   got;
        w   = int'((addr >> 2) & 32'hFF);
        mis = (addr % 4) != 0;
        oor = addr >= 32'd1024;
        ro  = wr && (w < ro_of(k));
        e.k     = k;
        e.err   = mis | oor | ro;
        e.waits = waits_of(k);
        e.data  = '0;
        e.mask  = '1;
        if (!e.err) begin
            if (!wr) begin
                for (int i = 0; i < 4; i++) begin
                    e.mask[8*i +: 8] = mknown[k][w][i] ? 8'hFF : 8'h00;
                end
                e.data = mdat[k][w] & e.mask;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (st[i]) begin
                        mdat[k][w][8*i +: 8] = wd[8*i +: 8];
                        mknown[k][w][i]      = 1'b1;
                    end
                end
            end
        end
        q.push_back(e);

        sel     = k;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wd;
        pstrb   = st;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge pclk);
            if (pready_v[k]) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL timeout dut=%0d addr=%h: no pready seen, required within 32 cycles", k, addr);
            if (q.size() > 0) void'(q.pop_back());
        end
    endtask

    always @(negedge pclk) begin : monitor
        exp_t e;
        if (!preset_n) begin
            wcnt = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if ($isunknown({pready_v[k], pslverr_v[k]}) || (pslverr_v[k] && !pready_v[k])) begin
                    bad++;
                    $display("FAIL handshake dut=%0d: pready=%b pslverr=%b, required known and pslverr only with pready",
                             k, pready_v[k], pslverr_v[k]);
                end
            end
            if (psel && penable && !pready_v[sel]) wcnt++;
            for (int k = 0; k < 3; k++) begin
                if (pready_v[k]) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected dut=%0d: pready=1 with no transfer outstanding", k);
                    end else begin
                        e = q.pop_front();
                        total += 3;
                        if (e.k != k) begin
                            bad++;
                            $display("FAIL route: pready from dut=%0d, required dut=%0d", k, e.k);
                        end
                        if (pslverr_v[k] !== e.err) begin
                            bad++;
                            $display("FAIL pslverr dut=%0d: got %b, required %b", k, pslverr_v[k], e.err);
                        end
                        if ((prdata_v[k] & e.mask) !== e.data) begin
                            bad++;
                            $display("FAIL prdata dut=%0d: got %h, required %h (mask %h)",
                                     k, prdata_v[k], e.data, e.mask);
                        end
                        if (wcnt != e.waits) begin
                            bad++;
                            $display("FAIL waits dut=%0d: got %0d, required %0d", k, wcnt, e.waits);
                        end
                    end
                    wcnt = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r, k;
        logic [31:0] a;
        preset_n = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; sel = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 256; j++)
                mknown[i][j] = 4'h0;
        #2 preset_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            total += 3;
            if (pready_v[i] !== 1'b0) begin bad++; $display("FAIL rst_pready dut=%0d: got %b, required 0", i, pready_v[i]); end
            if (pslverr_v[i] !== 1'b0) begin bad++; $display("FAIL rst_pslverr dut=%0d: got %b, required 0", i, pslverr_v[i]); end
            if (prdata_v[i] !== 32'h0) begin bad++; $display("FAIL rst_prdata dut=%0d: got %h, required 0", i, prdata_v[i]); end
        end
        preset_n = 1'b1;
        @(posedge pclk); #1;

        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 16; w++)
                issue(i, 32'(w * 4), 1'b1, $urandom, 4'hF);

        issue(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
        issue(0, 32'h10, 1'b0, 32'h0, 4'hF);
        issue(0, 32'h20, 1'b1, 32'h11223344, 4'hF);
        issue(0, 32'h20, 1'b1, 32'hAABBCCDD, 4'h5);
        issue(0, 32'h20, 1'b0, 32'h0, 4'h0);
        issue(1, 32'h44, 1'b0, 32'h0, 4'hF);
        issue(0, 32'h402, 1'b1, 32'hFFFFFFFF, 4'hF);
        issue(0, 32'h400, 1'b1, 32'hFFFFFFFF, 4'hF);
        issue(0, 32'h400, 1'b0, 32'h0, 4'hF);
        issue(0, 32'h04, 1'b1, 32'h55AA55AA, 4'hF);
        issue(0, 32'h04, 1'b0, 32'h0, 4'hF);
        issue(1, 32'h402, 1'b1, 32'hFFFFFFFF, 4'hF);
        issue(1, 32'h400, 1'b1, 32'hFFFFFFFF, 4'hF);
        issue(1, 32'h00, 1'b0, 32'h0, 4'hF);
        issue(1, 32'h08, 1'b1, 32'h0BADF00D, 4'h0);
        issue(1, 32'h08, 1'b0, 32'h0, 4'hF);

        // Reset landing in the middle of a waited write must drop the write.
        issue(2, 32'h30, 1'b1, 32'hCAFE0030, 4'hF);
        issue(2, 32'h30, 1'b0, 32'h0, 4'hF);
        sel = 2; paddr = 32'h30; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF;
        psel = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset_n = 1'b0;
        #1;
        total += 2;
        if (pready_v[2] !== 1'b0) begin bad++; $display("FAIL abort_pready: got %b, required 0", pready_v[2]); end
        if (prdata_v[2] !== 32'h0) begin bad++; $display("FAIL abort_prdata: got %h, required 0", prdata_v[2]); end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        preset_n = 1'b1;
        @(posedge pclk); #1;
        issue(2, 32'h30, 1'b0, 32'h0, 4'hF);

        for (int n = 0; n < 150; n++) begin
            k = int'($urandom_range(0, 2));
            r = int'($urandom_range(0, 19));
            if (r < 16)       a = 32'(r * 4);
            else if (r == 16) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (r == 17) a = 32'h400 + 32'($urandom_range(0, 255) * 4);
            else if (r == 18) a = 32'h8000_0000 | 32'($urandom_range(0, 15) * 4);
            else              a = 32'($urandom_range(0, 255) * 4);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge pclk); #1;
            end
            issue(k, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
        end

        repeat (4) @(posedge pclk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected responses left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
